// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the LPDDR2 word-port arbiter.
package mem_arb_pkg;

  // Requester-side word address width; the controller side is narrower.
  localparam int REQ_ADDR_W     = 30;

  localparam int ADDR_W_DEF     = 27;
  localparam int DATA_W_DEF     = 32;
  localparam int TIMEOUT_DEF    = 255;
  localparam int MAX_DBURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

  // True when any requester address bit above the controller width is set.
  function automatic logic addr_out_of_range(input logic [REQ_ADDR_W-1:0] addr,
                                             input int addr_w);
    logic oor;
    oor = 1'b0;
    for (int i = 0; i < REQ_ADDR_W; i++) begin
      if ((i >= addr_w) && addr[i]) begin
        oor = 1'b1;
      end
    end
    return oor;
  endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Grant decision between fetch and load/store with a bounded starvation
// counter: data normally wins, but fetch is forced through after
// MAX_DBURST consecutive data grants that it had to wait behind.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int MAX_DBURST = MAX_DBURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic idle,
  output logic grant
);

  localparam int                CNT_W   = $clog2(MAX_DBURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DBURST);

  logic [CNT_W-1:0] dburst_cnt;
  logic             fetch_starved;

  assign fetch_starved = (dburst_cnt >= CNT_MAX);

  // Combinational grant; only consumed by the top while it sits in IDLE.
  always_comb begin
    grant = GNT_D;
    if (if_req && (!d_req || fetch_starved)) begin
      grant = GNT_IF;
    end
  end

  // Count data grants taken while fetch was waiting; saturate, never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dburst_cnt <= '0;
    end else if (idle) begin
      if (!if_req || (grant == GNT_IF)) begin
        dburst_cnt <= '0;
      end else if (d_req && !fetch_starved) begin
        dburst_cnt <= dburst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store traffic onto the single LPDDR2 word port.
// One transaction in flight at a time; out-of-range addresses and stalled
// reads are completed locally with an error pulse alongside the ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MAX_DBURST = MAX_DBURST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [REQ_ADDR_W-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [REQ_ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic [ADDR_W-1:0]     lpddr2_address,
  output logic [DATA_W-1:0]     lpddr2_write_data,
  input  logic [DATA_W-1:0]     lpddr2_read_data,
  output logic                  lpddr2_rreq,
  output logic                  lpddr2_wreq,
  input  logic                  lpddr2_wait,
  input  logic                  lpddr2_rvalid,
  output logic                  err_range,
  output logic                  err_timeout,
  output logic                  busy
);

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  state_t                  state;
  logic                    fair_gnt;
  grant_t                  gnt_sel;
  grant_t                  gnt_q;
  logic                    any_req;
  logic [REQ_ADDR_W-1:0]   sel_addr;
  logic                    sel_we;
  logic [DATA_W-1:0]       sel_wdata;
  logic                    sel_oor;
  logic                    we_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    rng_q;
  logic                    tmo_q;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    in_flight;
  logic                    tmo_hit;
  logic                    accept;

  mem_arb_fairness #(
    .MAX_DBURST (MAX_DBURST)
  ) u_fairness (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .idle   (state == IDLE),
    .grant  (fair_gnt)
  );

  assign any_req   = if_req | d_req;
  assign gnt_sel   = grant_t'(fair_gnt);
  assign sel_oor   = addr_out_of_range(sel_addr, ADDR_W);
  assign in_flight = (state == ISSUE) || (state == RD_WAIT);
  assign tmo_hit   = in_flight && (tmo_cnt == TMO_LIMIT);
  assign accept    = (state == ISSUE) && !lpddr2_wait;
  assign busy      = (state != IDLE);

  // Steer the winning requester's address, direction and write data.
  always_comb begin
    sel_addr  = d_addr;
    sel_we    = d_we;
    sel_wdata = d_wdata;
    if (gnt_sel == GNT_IF) begin
      sel_addr  = if_addr;
      sel_we    = 1'b0;
      sel_wdata = '0;
    end
  end

  // Main FSM: latch the grant in IDLE, drive the controller request, collect read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      gnt_q             <= GNT_IF;
      we_q              <= 1'b0;
      lpddr2_address    <= '0;
      lpddr2_write_data <= '0;
      lpddr2_rreq       <= 1'b0;
      lpddr2_wreq       <= 1'b0;
      rdata_q           <= '0;
      rng_q             <= 1'b0;
      tmo_q             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q             <= gnt_sel;
            we_q              <= sel_we;
            lpddr2_address    <= sel_addr[ADDR_W-1:0];
            lpddr2_write_data <= sel_wdata;
            rdata_q           <= '0;
            tmo_q             <= 1'b0;
            if (sel_oor) begin
              // Never reaches the controller; a write is simply dropped.
              rng_q <= 1'b1;
              state <= RESP;
            end else begin
              rng_q       <= 1'b0;
              lpddr2_rreq <= !sel_we;
              lpddr2_wreq <= sel_we;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (tmo_hit) begin
            lpddr2_rreq <= 1'b0;
            lpddr2_wreq <= 1'b0;
            tmo_q       <= 1'b1;
            state       <= RESP;
          end else if (accept) begin
            lpddr2_rreq <= 1'b0;
            lpddr2_wreq <= 1'b0;
            state       <= we_q ? RESP : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (tmo_hit) begin
            tmo_q <= 1'b1;
            state <= RESP;
          end else if (lpddr2_rvalid) begin
            rdata_q <= lpddr2_read_data;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Cycles spent waiting on the controller; cleared whenever nothing is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (in_flight) begin
      if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Ack, read data and error pulses, all issued together on leaving RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      if (state == RESP) begin
        err_range   <= rng_q;
        err_timeout <= tmo_q;
        if (gnt_q == GNT_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= rdata_q;
        end else begin
          d_ack   <= 1'b1;
          d_rdata <= rdata_q;
        end
      end
    end
  end

endmodule
